i2c_byte_ctrl: RTL and testbench

- Byte-level command sequencer between the I2C controller's WISHBONE register file (CR/TXR/RXR/SR) and the bit-level SCL/SDA engine.
- Takes one register-level command set (START, STOP, RD, WR, ACK) per host write. Breaks it into bit-controller commands (START, STOP, WRITE bit, READ bit), shifts TXR out MSB-first, assembles RXR, and returns a single-cycle done pulse plus the received ACK bit.
- Aborts cleanly on arbitration loss.

---
 rtl/i2c_byte_ctrl_if.sv | 36 +++
 rtl/i2c_byte_ctrl.sv | 176 +++++++++++++++++
 tb/tb_i2c_byte_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_byte_ctrl_if.sv
// Signal bundle between the I2C register file / bit-level engine and the byte sequencer.
// The sequencer sits on the slave side; the register file and bit engine together form the master side.
interface i2c_byte_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              ena;
    logic              start;
    logic              stop;
    logic              read;
    logic              write;
    logic              ack_in;
    logic [DATA_W-1:0] din;
    logic              cmd_ack;
    logic              ack_out;
    logic [DATA_W-1:0] dout;
    logic              i2c_busy;
    logic              i2c_al;
    logic [3:0]        core_cmd;
    logic              core_txd;
    logic              core_ack;
    logic              core_rxd;
    logic              bit_busy;
    logic              bit_al;

    modport master (
        output ena, start, stop, read, write, ack_in, din,
        output core_ack, core_rxd, bit_busy, bit_al,
        input  cmd_ack, ack_out, dout, i2c_busy, i2c_al, core_cmd, core_txd
    );

    modport slave (
        input  ena, start, stop, read, write, ack_in, din,
        input  core_ack, core_rxd, bit_busy, bit_al,
        output cmd_ack, ack_out, dout, i2c_busy, i2c_al, core_cmd, core_txd
    );
endinterface

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C command sequencer: turns one START/STOP/RD/WR/ACK register command
// into a series of bit-engine commands, shifting TXR out and RXR in MSB-first.
module i2c_byte_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic           wb_clk_i,
    input  logic           arst_i,
    input  logic           wb_rst_i,
    i2c_byte_ctrl_if.slave bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [3:0] CMD_NOP   = 4'h0;
    localparam logic [3:0] CMD_START = 4'h1;
    localparam logic [3:0] CMD_STOP  = 4'h2;
    localparam logic [3:0] CMD_WRITE = 4'h4;
    localparam logic [3:0] CMD_READ  = 4'h8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        cmd, cmd_nxt;
    logic              txd, txd_nxt;
    logic              done, done_nxt;
    logic              ack, ack_nxt;
    logic [DATA_W-1:0] sr, sr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              go;
    logic              abort;

    // Data phase chosen after an optional START: read wins over write, stop alone otherwise.
    function automatic state_t dispatch(input logic rd, input logic wr);
        if (rd)
            return ST_READ;
        else if (wr)
            return ST_WRITE;
        else
            return ST_STOP;
    endfunction

    function automatic logic [3:0] cmd_of(input state_t st);
        case (st)
            ST_START: return CMD_START;
            ST_READ:  return CMD_READ;
            ST_WRITE: return CMD_WRITE;
            ST_STOP:  return CMD_STOP;
            default:  return CMD_NOP;
        endcase
    endfunction

    // cmd_ack masks go for one cycle so the register file can clear its command bits.
    assign go    = (bus.read | bus.write | bus.stop) & ~done;
    assign abort = bus.bit_al | (~bus.ena & (state != ST_IDLE));

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state <= ST_IDLE;
            cmd   <= CMD_NOP;
            txd   <= 1'b0;
            done  <= 1'b0;
            ack   <= 1'b0;
            sr    <= '0;
            cnt   <= '0;
        end else if (wb_rst_i) begin
            state <= ST_IDLE;
            cmd   <= CMD_NOP;
            txd   <= 1'b0;
            done  <= 1'b0;
            ack   <= 1'b0;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cmd   <= cmd_nxt;
            txd   <= txd_nxt;
            done  <= done_nxt;
            ack   <= ack_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        txd_nxt   = txd;
        done_nxt  = 1'b0;
        ack_nxt   = ack;
        sr_nxt    = sr;
        cnt_nxt   = cnt;

        if (abort) begin
            // Arbitration loss or disable: drop the transfer silently, keep the shift register.
            state_nxt = ST_IDLE;
            cmd_nxt   = CMD_NOP;
            txd_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go && bus.ena) begin
                        sr_nxt    = bus.din;
                        cnt_nxt   = CNT_W'(DATA_W - 1);
                        state_nxt = bus.start ? ST_START : dispatch(bus.read, bus.write);
                        cmd_nxt   = cmd_of(state_nxt);
                        if (state_nxt == ST_WRITE)
                            txd_nxt = bus.din[DATA_W-1];
                    end
                end
                ST_START: begin
                    if (bus.core_ack) begin
                        state_nxt = dispatch(bus.read, bus.write);
                        cmd_nxt   = cmd_of(state_nxt);
                        if (state_nxt == ST_WRITE)
                            txd_nxt = sr[DATA_W-1];
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (bus.core_ack) begin
                        sr_nxt  = {sr[DATA_W-2:0], bus.core_rxd};
                        cnt_nxt = cnt - 1'b1;
                        txd_nxt = sr[DATA_W-2];
                        if (cnt == '0) begin
                            state_nxt = ST_ACK;
                            if (state == ST_READ) begin
                                cmd_nxt = CMD_WRITE;
                                txd_nxt = bus.ack_in;
                            end else begin
                                cmd_nxt = CMD_READ;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    if (bus.core_ack) begin
                        ack_nxt = bus.core_rxd;
                        if (bus.stop) begin
                            state_nxt = ST_STOP;
                            cmd_nxt   = CMD_STOP;
                        end else begin
                            state_nxt = ST_IDLE;
                            cmd_nxt   = CMD_NOP;
                            done_nxt  = 1'b1;
                            txd_nxt   = 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bus.core_ack) begin
                        state_nxt = ST_IDLE;
                        cmd_nxt   = CMD_NOP;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cmd_nxt   = CMD_NOP;
                end
            endcase
        end
    end

    assign bus.cmd_ack  = done;
    assign bus.ack_out  = ack;
    assign bus.dout     = sr;
    assign bus.core_cmd = cmd;
    assign bus.core_txd = txd;
    assign bus.i2c_busy = bus.bit_busy;
    assign bus.i2c_al   = bus.bit_al;
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Bench for i2c_byte_ctrl: acts as register file and bit engine, compares the issued
// bit-command stream and results against a transaction-level model.
module tb_i2c_byte_ctrl;
    localparam int DATA_W = 8;
    localparam logic [3:0] C_NOP   = 4'h0;
    localparam logic [3:0] C_START = 4'h1;
    localparam logic [3:0] C_STOP  = 4'h2;
    localparam logic [3:0] C_WRITE = 4'h4;
    localparam logic [3:0] C_READ  = 4'h8;

    logic clk = 1'b0;
    logic arst_n;
    logic wb_rst;

    i2c_byte_ctrl_if #(.DATA_W(DATA_W)) bus();

    i2c_byte_ctrl #(.DATA_W(DATA_W)) dut (
        .wb_clk_i (clk),
        .arst_i   (arst_n),
        .wb_rst_i (wb_rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s, p, r, w, a;
        logic [7:0] din;
        logic [7:0] rxd;
        logic       rxa;
        int         exp_ncmd;
        logic [7:0] exp_dout;
        logic       exp_ack;
    } vec_t;

    int         npass  = 0;
    int         ntotal = 0;
    logic [3:0] obs_cmd[$];
    logic       obs_txd[$];
    logic [3:0] exp_cmd[$];
    logic       exp_txd[$];
    bit         exp_care[$];
    logic [7:0] m_dout;
    logic       m_ack;
    vec_t       tbl[6];
    logic       rs, rp, rr, rw, ra, rxa_r;
    logic [7:0] rdin, rrx;
    int         n, bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp)
            npass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Transaction-level expectation: what bit commands a command set must produce.
    task automatic model(input logic s, p, r, w, a, input logic [7:0] d, rxd, input logic rxa);
        exp_cmd.delete(); exp_txd.delete(); exp_care.delete();
        if (s) begin exp_cmd.push_back(C_START); exp_txd.push_back(1'b0); exp_care.push_back(0); end
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                exp_cmd.push_back(C_READ); exp_txd.push_back(1'b0); exp_care.push_back(0);
            end
            exp_cmd.push_back(C_WRITE); exp_txd.push_back(a); exp_care.push_back(1);
        end else if (w) begin
            for (int i = 0; i < 8; i++) begin
                exp_cmd.push_back(C_WRITE); exp_txd.push_back(d[7-i]); exp_care.push_back(1);
            end
            exp_cmd.push_back(C_READ); exp_txd.push_back(1'b0); exp_care.push_back(0);
        end
        if (p) begin exp_cmd.push_back(C_STOP); exp_txd.push_back(1'b0); exp_care.push_back(0); end
        if (r | w) begin
            m_dout = rxd;
            m_ack  = rxa;
        end else begin
            m_dout = d;
        end
    endtask

    // Runs one command set with a bit engine that acks every command one cycle after issue.
    task automatic do_txn(input string tag, input logic s, p, r, w, a,
                          input logic [7:0] d, rxd, input logic rxa);
        int idx   = 0;
        int extra = 0;
        int mi    = -1;
        bit done  = 0;
        bit lat   = 0;
        model(s, p, r, w, a, d, rxd, rxa);
        obs_cmd.delete(); obs_txd.delete();
        bus.start = s; bus.stop = p; bus.read = r; bus.write = w;
        bus.ack_in = a; bus.din = d; bus.core_ack = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(posedge clk); #1;
            if (bus.cmd_ack) begin
                lat = bus.core_ack;
                bus.core_ack = 1'b0;
                done = 1;
            end else if (bus.core_ack) begin
                bus.core_ack = 1'b0;
            end else if (bus.core_cmd != C_NOP) begin
                obs_cmd.push_back(bus.core_cmd);
                obs_txd.push_back(bus.core_txd);
                bus.core_ack = 1'b1;
                if (bus.core_cmd == C_READ || bus.core_cmd == C_WRITE) begin
                    bus.core_rxd = (idx < 8) ? rxd[7-idx] : rxa;
                    idx++;
                end else begin
                    bus.core_rxd = 1'($urandom);
                end
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd1);
        // Command bits stay set through the cmd_ack cycle, as the register file clears them late.
        @(posedge clk); #1;
        if (bus.cmd_ack || bus.core_cmd != C_NOP) extra++;
        bus.start = 0; bus.stop = 0; bus.read = 0; bus.write = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.cmd_ack || bus.core_cmd != C_NOP) extra++;
        end
        check({tag, "_no_relaunch"}, 32'(extra), 32'd0);
        check({tag, "_seq_len"}, 32'(obs_cmd.size()), 32'(exp_cmd.size()));
        for (int i = 0; i < obs_cmd.size() && i < exp_cmd.size() && mi < 0; i++)
            if (obs_cmd[i] !== exp_cmd[i] || (exp_care[i] && obs_txd[i] !== exp_txd[i]))
                mi = i;
        check({tag, "_seq_first_bad_idx"}, 32'(mi), 32'hFFFF_FFFF);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 10, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h6C, 1'b0, 10, 8'h6C, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1,  8'h3C, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 8'hFF, 1'b1, 9,  8'hFF, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 8'h81, 1'b1, 11, 8'h81, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2,  8'h00, 1'b1};

        arst_n = 1'b0; wb_rst = 1'b0;
        bus.ena = 1'b1; bus.start = 0; bus.stop = 0; bus.read = 0; bus.write = 0;
        bus.ack_in = 0; bus.din = '0; bus.core_ack = 0; bus.core_rxd = 0;
        bus.bit_busy = 0; bus.bit_al = 0;
        m_ack = 1'b0; m_dout = '0;
        #12;
        check("rst_core_cmd", 32'(bus.core_cmd), 32'(C_NOP));
        check("rst_cmd_ack",  32'(bus.cmd_ack), 32'd0);
        check("rst_ack_out",  32'(bus.ack_out), 32'd0);
        check("rst_dout",     32'(bus.dout), 32'd0);
        check("rst_core_txd", 32'(bus.core_txd), 32'd0);
        @(posedge clk); #1; arst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a write byte.
        bus.write = 1'b1; bus.din = 8'hFF; n = 0;
        for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
            @(posedge clk); #1;
            if (bus.core_ack) bus.core_ack = 1'b0;
            else if (bus.core_cmd != C_NOP) begin n++; bus.core_ack = 1'b1; bus.core_rxd = 1'b1; end
        end
        @(posedge clk); #1; bus.core_ack = 1'b0;
        check("mid_write_cmd", 32'(bus.core_cmd), 32'(C_WRITE));
        #2 arst_n = 1'b0;
        #1;
        check("arst_core_cmd", 32'(bus.core_cmd), 32'(C_NOP));
        check("arst_cmd_ack",  32'(bus.cmd_ack), 32'd0);
        check("arst_dout",     32'(bus.dout), 32'd0);
        bus.write = 1'b0;
        @(posedge clk); #1; arst_n = 1'b1; bus.core_ack = 1'b1; bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.core_cmd != C_NOP || bus.cmd_ack) bad++;
        end
        bus.core_ack = 1'b0;
        check("idle_ignores_core_ack", 32'(bad), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i].s, tbl[i].p, tbl[i].r, tbl[i].w, tbl[i].a,
                   tbl[i].din, tbl[i].rxd, tbl[i].rxa);
            check($sformatf("vec%0d_ncmd", i), 32'(obs_cmd.size()), 32'(tbl[i].exp_ncmd));
            check($sformatf("vec%0d_dout", i), 32'(bus.dout), 32'(tbl[i].exp_dout));
            check($sformatf("vec%0d_ack_out", i), 32'(bus.ack_out), 32'(tbl[i].exp_ack));
        end

        // Synchronous reset clears the NACK left by the previous transfer.
        check("pre_wbrst_ack_out", 32'(bus.ack_out), 32'd1);
        wb_rst = 1'b1;
        @(posedge clk); #1; wb_rst = 1'b0;
        check("wbrst_ack_out", 32'(bus.ack_out), 32'd0);
        check("wbrst_dout", 32'(bus.dout), 32'd0);
        m_ack = 1'b0;

        // Arbitration loss coinciding with the ack of the 4th WRITE bit.
        bus.write = 1'b1; bus.din = 8'hA5; bus.core_rxd = 1'b0; n = 0;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            @(posedge clk); #1;
            if (bus.core_ack) bus.core_ack = 1'b0;
            else if (bus.core_cmd == C_WRITE) begin
                n++;
                bus.core_ack = 1'b1;
                if (n == 4) bus.bit_al = 1'b1;
            end
        end
        #1;
        check("al_passthrough", 32'(bus.i2c_al), 32'd1);
        @(posedge clk); #1;
        check("al_core_cmd", 32'(bus.core_cmd), 32'(C_NOP));
        check("al_cmd_ack",  32'(bus.cmd_ack), 32'd0);
        check("al_core_txd", 32'(bus.core_txd), 32'd0);
        check("al_dout_kept", 32'(bus.dout), 32'h28);
        bus.bit_al = 1'b0; bus.core_ack = 1'b0; bus.write = 1'b0; bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.core_cmd != C_NOP || bus.cmd_ack) bad++;
        end
        check("al_stays_idle", 32'(bad), 32'd0);

        // Disabling the core mid-read aborts; while disabled nothing launches.
        bus.read = 1'b1; bus.core_rxd = 1'b1; n = 0;
        for (int cyc = 0; cyc < 60 && n < 2; cyc++) begin
            @(posedge clk); #1;
            if (bus.core_ack) bus.core_ack = 1'b0;
            else if (bus.core_cmd != C_NOP) begin n++; bus.core_ack = 1'b1; end
        end
        @(posedge clk); #1; bus.core_ack = 1'b0;
        check("ena_pre_cmd", 32'(bus.core_cmd), 32'(C_READ));
        bus.ena = 1'b0;
        @(posedge clk); #1;
        check("ena_abort_cmd", 32'(bus.core_cmd), 32'(C_NOP));
        check("ena_abort_cmd_ack", 32'(bus.cmd_ack), 32'd0);
        bus.read = 1'b0; bus.write = 1'b1; bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.core_cmd != C_NOP || bus.cmd_ack) bad++;
        end
        check("ena_hold_idle", 32'(bad), 32'd0);
        bus.write = 1'b0; bus.ena = 1'b1;

        bus.bit_busy = 1'b1; #1;
        check("busy_high", 32'(bus.i2c_busy), 32'd1);
        bus.bit_busy = 1'b0; #1;
        check("busy_low", 32'(bus.i2c_busy), 32'd0);
        @(posedge clk); #1;

        for (int k = 0; k < 30; k++) begin
            rs = 1'($urandom); rp = 1'($urandom); rr = 1'($urandom); rw = 1'($urandom);
            ra = 1'($urandom); rxa_r = 1'($urandom);
            rdin = 8'($urandom); rrx = 8'($urandom);
            if (!(rr | rw | rp)) rp = 1'b1;
            do_txn($sformatf("rnd%0d", k), rs, rp, rr, rw, ra, rdin, rrx, rxa_r);
            check($sformatf("rnd%0d_dout", k), 32'(bus.dout), 32'(m_dout));
            check($sformatf("rnd%0d_ack_out", k), 32'(bus.ack_out), 32'(m_ack));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
